// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control FSM: state encoding,
// opcode/funct constants, ALU control codes and datapath mux encodings.
package mips_ctrl_pkg;

    // Controller states; the numeric values are visible on the STATE debug port
    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEM_ADDR = 4'd2,
        ST_MEM_RD   = 4'd3,
        ST_MEM_WB   = 4'd4,
        ST_MEM_WR   = 4'd5,
        ST_EXEC     = 4'd6,
        ST_ALU_WB   = 4'd7,
        ST_BRANCH   = 4'd8,
        ST_JUMP     = 4'd9,
        ST_ILLEGAL  = 4'd10
    } state_e;

    // Primary opcodes (IR[31:26])
    localparam logic [5:0] OP_ALU = 6'h02;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_SW  = 6'h2B;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_J   = 6'h03;

    // Function field values for ALU-class instructions (IR[5:0])
    localparam logic [5:0] FN_NOP = 6'h00;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // ALU operation codes
    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;

    // PC source mux encodings
    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    // ALU B-operand mux encodings
    localparam logic [1:0] SRCB_REG    = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    // Loads and stores share the address-calculation state
    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mips_alu_decode.sv
// Combinational FUNCT decoder: maps the function field of an ALU-class
// instruction to an ALU control code and flags unsupported encodings.
module mips_alu_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] funct_i,
    output logic [3:0] alu_ctrl_o,
    output logic       funct_valid_o
);

    // Map function field to ALU operation; unknown codes are marked invalid
    always_comb begin
        alu_ctrl_o    = ALU_ADD;
        funct_valid_o = 1'b1;
        case (funct_i)
            FN_NOP,
            FN_ADD:  alu_ctrl_o = ALU_ADD;
            FN_SUB:  alu_ctrl_o = ALU_SUB;
            FN_AND:  alu_ctrl_o = ALU_AND;
            FN_OR:   alu_ctrl_o = ALU_OR;
            FN_SLT:  alu_ctrl_o = ALU_SLT;
            default: begin
                alu_ctrl_o    = ALU_ADD;
                funct_valid_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM. Sequences fetch/decode/execute through the
// shared-memory datapath and drives every enable and mux select. Outputs are
// decoded from the current state (plus MEM_READY in FETCH, where IR/PC loads
// follow the memory handshake) and are forced to zero while RESET is low.
// Optional macro CTRL_PERF_CNT_EN adds the RETIRED_CNT retirement counter.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter logic [3:0] RESET_STATE    = 4'd0,
    parameter logic       DECODE_ILLEGAL = 1'b1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [5:0]  OPCODE,
    input  logic [5:0]  FUNCT,
    input  logic        ZERO,
    input  logic        MEM_READY,
    output logic        PC_WRITE,
    output logic        PC_WRITE_COND,
    output logic [1:0]  PC_SOURCE,
    output logic        IORD,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic        IR_WRITE,
    output logic        REG_DST,
    output logic        MEM_TO_REG,
    output logic        REG_WRITE,
    output logic        ALU_SRC_A,
    output logic [1:0]  ALU_SRC_B,
    output logic [3:0]  ALU_CTRL,
    output logic        ILLEGAL_OP,
    output logic [3:0]  STATE
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [31:0] RETIRED_CNT
`endif
);

    // Where an undecodable instruction goes after DECODE
    localparam state_e ILLEGAL_DEST = DECODE_ILLEGAL ? ST_ILLEGAL : ST_FETCH;

    state_e      state_q;
    state_e      state_d;

    logic [3:0]  funct_alu_ctrl_s;
    logic        funct_valid_s;

    logic        pc_write_s;
    logic        pc_write_cond_s;
    logic [1:0]  pc_source_s;
    logic        iord_s;
    logic        mem_read_s;
    logic        mem_write_s;
    logic        ir_write_s;
    logic        reg_dst_s;
    logic        mem_to_reg_s;
    logic        reg_write_s;
    logic        alu_src_a_s;
    logic [1:0]  alu_src_b_s;
    logic [3:0]  alu_ctrl_s;
    logic        illegal_op_s;
    logic        retire_s;

    // The branch comparison is resolved in the datapath (PC_WRITE_COND & ZERO)
    logic        unused_s;

    mips_alu_decode u_alu_decode (
        .funct_i       (FUNCT),
        .alu_ctrl_o    (funct_alu_ctrl_s),
        .funct_valid_o (funct_valid_s)
    );

    // State register; reset abandons any instruction in flight
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= state_e'(RESET_STATE);
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath control decode
    always_comb begin
        state_d         = ST_FETCH;
        pc_write_s      = 1'b0;
        pc_write_cond_s = 1'b0;
        pc_source_s     = PCSRC_ALU;
        iord_s          = 1'b0;
        mem_read_s      = 1'b0;
        mem_write_s     = 1'b0;
        ir_write_s      = 1'b0;
        reg_dst_s       = 1'b0;
        mem_to_reg_s    = 1'b0;
        reg_write_s     = 1'b0;
        alu_src_a_s     = 1'b0;
        alu_src_b_s     = SRCB_REG;
        alu_ctrl_s      = ALU_AND;
        illegal_op_s    = 1'b0;
        retire_s        = 1'b0;

        case (state_q)
            ST_FETCH: begin
                // Read instruction at PC while the ALU forms PC+4; IR and PC
                // load in the cycle the memory reports completion.
                mem_read_s  = 1'b1;
                iord_s      = 1'b0;
                alu_src_a_s = 1'b0;
                alu_src_b_s = SRCB_FOUR;
                alu_ctrl_s  = ALU_ADD;
                pc_source_s = PCSRC_ALU;
                ir_write_s  = MEM_READY;
                pc_write_s  = MEM_READY;
                if (MEM_READY) begin
                    state_d = ST_DECODE;
                end else begin
                    state_d = ST_FETCH;
                end
            end

            ST_DECODE: begin
                // Precompute the branch target speculatively
                alu_src_a_s = 1'b0;
                alu_src_b_s = SRCB_IMM_SH;
                alu_ctrl_s  = ALU_ADD;
                if (is_mem_op(OPCODE)) begin
                    state_d = ST_MEM_ADDR;
                end else begin
                    case (OPCODE)
                        OP_ALU: begin
                            if (funct_valid_s) begin
                                state_d = ST_EXEC;
                            end else begin
                                state_d = ILLEGAL_DEST;
                            end
                        end
                        OP_BEQ:  state_d = ST_BRANCH;
                        OP_J:    state_d = ST_JUMP;
                        default: state_d = ILLEGAL_DEST;
                    endcase
                end
            end

            ST_MEM_ADDR: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = SRCB_IMM;
                alu_ctrl_s  = ALU_ADD;
                if (OPCODE == OP_LW) begin
                    state_d = ST_MEM_RD;
                end else if (OPCODE == OP_SW) begin
                    state_d = ST_MEM_WR;
                end else begin
                    state_d = ST_FETCH;
                end
            end

            ST_MEM_RD: begin
                // Request held stable until the memory completes
                mem_read_s = 1'b1;
                iord_s     = 1'b1;
                if (MEM_READY) begin
                    state_d = ST_MEM_WB;
                end else begin
                    state_d = ST_MEM_RD;
                end
            end

            ST_MEM_WB: begin
                reg_write_s  = 1'b1;
                mem_to_reg_s = 1'b1;
                reg_dst_s    = 1'b0;
                retire_s     = 1'b1;
                state_d      = ST_FETCH;
            end

            ST_MEM_WR: begin
                mem_write_s = 1'b1;
                iord_s      = 1'b1;
                if (MEM_READY) begin
                    retire_s = 1'b1;
                    state_d  = ST_FETCH;
                end else begin
                    state_d  = ST_MEM_WR;
                end
            end

            ST_EXEC: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = SRCB_REG;
                alu_ctrl_s  = funct_alu_ctrl_s;
                state_d     = ST_ALU_WB;
            end

            ST_ALU_WB: begin
                reg_write_s  = 1'b1;
                reg_dst_s    = 1'b1;
                mem_to_reg_s = 1'b0;
                retire_s     = 1'b1;
                state_d      = ST_FETCH;
            end

            ST_BRANCH: begin
                // Compare A-B; the datapath qualifies the PC load with ZERO
                alu_src_a_s     = 1'b1;
                alu_src_b_s     = SRCB_REG;
                alu_ctrl_s      = ALU_SUB;
                pc_write_cond_s = 1'b1;
                pc_source_s     = PCSRC_ALUOUT;
                retire_s        = 1'b1;
                state_d         = ST_FETCH;
            end

            ST_JUMP: begin
                pc_write_s  = 1'b1;
                pc_source_s = PCSRC_JUMP;
                retire_s    = 1'b1;
                state_d     = ST_FETCH;
            end

            ST_ILLEGAL: begin
                // Single-cycle trap indication, nothing is written
                illegal_op_s = DECODE_ILLEGAL;
                state_d      = ST_FETCH;
            end

            default: begin
                // Encodings 11..15 cannot be reached; recover quietly
                state_d = ST_FETCH;
            end
        endcase
    end

    // Outputs are held at zero while reset is asserted
    assign PC_WRITE      = RESET & pc_write_s;
    assign PC_WRITE_COND = RESET & pc_write_cond_s;
    assign PC_SOURCE     = RESET ? pc_source_s : 2'b00;
    assign IORD          = RESET & iord_s;
    assign MEM_READ      = RESET & mem_read_s;
    assign MEM_WRITE     = RESET & mem_write_s;
    assign IR_WRITE      = RESET & ir_write_s;
    assign REG_DST       = RESET & reg_dst_s;
    assign MEM_TO_REG    = RESET & mem_to_reg_s;
    assign REG_WRITE     = RESET & reg_write_s;
    assign ALU_SRC_A     = RESET & alu_src_a_s;
    assign ALU_SRC_B     = RESET ? alu_src_b_s : 2'b00;
    assign ALU_CTRL      = RESET ? alu_ctrl_s : 4'b0000;
    assign ILLEGAL_OP    = RESET & illegal_op_s;
    assign STATE         = RESET ? state_q : 4'b0000;

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] retired_cnt_q;
    logic [31:0] retired_cnt_d;

    // Count completed instructions; wraps naturally at 32 bits
    always_comb begin
        if (retire_s) begin
            retired_cnt_d = retired_cnt_q + 32'd1;
        end else begin
            retired_cnt_d = retired_cnt_q;
        end
    end

    // Retirement counter register, cleared by reset
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            retired_cnt_q <= 32'd0;
        end else begin
            retired_cnt_q <= retired_cnt_d;
        end
    end

    assign RETIRED_CNT = retired_cnt_q;
    assign unused_s    = ZERO;
`else
    assign unused_s    = ZERO ^ retire_s;
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl. Expected per-cycle output
// vectors are queued as each instruction is issued and compared cycle by
// cycle. Define CTRL_PERF_CNT_EN to also check RETIRED_CNT.
module tb_mips_multicycle_ctrl;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [5:0]  OPCODE;
    logic [5:0]  FUNCT;
    logic        ZERO;
    logic        MEM_READY;
    logic        PC_WRITE, PC_WRITE_COND, IORD, MEM_READ, MEM_WRITE, IR_WRITE;
    logic        REG_DST, MEM_TO_REG, REG_WRITE, ALU_SRC_A, ILLEGAL_OP;
    logic [1:0]  PC_SOURCE, ALU_SRC_B;
    logic [3:0]  ALU_CTRL, STATE;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] RETIRED_CNT;
`endif

    int total_cnt = 0;
    int pass_cnt  = 0;
    int retired_exp = 0;

    typedef struct {
        logic        rdy;
        logic [22:0] vec;
        string       tag;
    } step_t;

    step_t sbq[$];

    logic [22:0] dut_vec;

    mips_multicycle_ctrl dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .OPCODE        (OPCODE),
        .FUNCT         (FUNCT),
        .ZERO          (ZERO),
        .MEM_READY     (MEM_READY),
        .PC_WRITE      (PC_WRITE),
        .PC_WRITE_COND (PC_WRITE_COND),
        .PC_SOURCE     (PC_SOURCE),
        .IORD          (IORD),
        .MEM_READ      (MEM_READ),
        .MEM_WRITE     (MEM_WRITE),
        .IR_WRITE      (IR_WRITE),
        .REG_DST       (REG_DST),
        .MEM_TO_REG    (MEM_TO_REG),
        .REG_WRITE     (REG_WRITE),
        .ALU_SRC_A     (ALU_SRC_A),
        .ALU_SRC_B     (ALU_SRC_B),
        .ALU_CTRL      (ALU_CTRL),
        .ILLEGAL_OP    (ILLEGAL_OP),
        .STATE         (STATE)
`ifdef CTRL_PERF_CNT_EN
        ,
        .RETIRED_CNT   (RETIRED_CNT)
`endif
    );

    always #5 CLK = ~CLK;

    assign dut_vec = {PC_WRITE, PC_WRITE_COND, PC_SOURCE, IORD, MEM_READ, MEM_WRITE,
                      IR_WRITE, REG_DST, MEM_TO_REG, REG_WRITE, ALU_SRC_A, ALU_SRC_B,
                      ALU_CTRL, ILLEGAL_OP, STATE};

    // Pack one expected output set in the same order as dut_vec
    function automatic logic [22:0] ov(
        input logic pcw, input logic pcwc, input logic [1:0] pcsrc,
        input logic iord, input logic mr, input logic mw, input logic irw,
        input logic rd, input logic m2r, input logic rw, input logic sa,
        input logic [1:0] sb, input logic [3:0] alu, input logic ill,
        input logic [3:0] st);
        return {pcw, pcwc, pcsrc, iord, mr, mw, irw, rd, m2r, rw, sa, sb, alu, ill, st};
    endfunction

    function automatic logic [22:0] v_fetch(input logic r);
        return ov(r, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, r, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 4'd2, 1'b0, 4'd0);
    endfunction
    function automatic logic [22:0] v_decode();
        return ov(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 4'd2, 1'b0, 4'd1);
    endfunction
    function automatic logic [22:0] v_memaddr();
        return ov(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 4'd2, 1'b0, 4'd2);
    endfunction
    function automatic logic [22:0] v_memrd();
        return ov(1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 4'd3);
    endfunction
    function automatic logic [22:0] v_memwb();
        return ov(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 4'd4);
    endfunction
    function automatic logic [22:0] v_memwr();
        return ov(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 4'd5);
    endfunction
    function automatic logic [22:0] v_exec(input logic [3:0] a);
        return ov(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, a, 1'b0, 4'd6);
    endfunction
    function automatic logic [22:0] v_aluwb();
        return ov(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 4'd7);
    endfunction
    function automatic logic [22:0] v_branch();
        return ov(1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 4'd6, 1'b0, 4'd8);
    endfunction
    function automatic logic [22:0] v_jump();
        return ov(1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 4'd9);
    endfunction
    function automatic logic [22:0] v_illegal();
        return ov(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b1, 4'd10);
    endfunction

    task automatic check(input string tag, input logic [22:0] got, input logic [22:0] exp);
        total_cnt++;
        assert (got === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    endtask

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        assert (got === exp) pass_cnt++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    endtask

    task automatic push(input logic rdy, input logic [22:0] v, input string tag);
        step_t s;
        s.rdy = rdy;
        s.vec = v;
        s.tag = tag;
        sbq.push_back(s);
    endtask

    // Apply each queued cycle: drive MEM_READY, compare at negedge, advance
    task automatic drain();
        step_t s;
        while (sbq.size() > 0) begin
            s = sbq.pop_front();
            MEM_READY = s.rdy;
            @(negedge CLK);
            check(s.tag, dut_vec, s.vec);
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic do_alu(input logic [5:0] fn, input logic [3:0] alu, input logic rdy_mid);
        OPCODE = 6'h02;
        FUNCT  = fn;
        push(1'b1, v_fetch(1'b1), "alu_fetch");
        push(rdy_mid, v_decode(), "alu_decode");
        push(rdy_mid, v_exec(alu), "alu_exec");
        push(rdy_mid, v_aluwb(), "alu_wb");
        drain();
        retired_exp++;
    endtask

    task automatic do_lw(input int waits);
        OPCODE = 6'h23;
        FUNCT  = 6'h11;
        push(1'b1, v_fetch(1'b1), "lw_fetch");
        push(1'b1, v_decode(), "lw_decode");
        push(1'b1, v_memaddr(), "lw_addr");
        for (int i = 0; i < waits; i++) push(1'b0, v_memrd(), "lw_rd_wait");
        push(1'b1, v_memrd(), "lw_rd");
        push(1'b1, v_memwb(), "lw_wb");
        drain();
        retired_exp++;
    endtask

    task automatic do_sw(input int fetch_waits);
        OPCODE = 6'h2B;
        FUNCT  = 6'h3F;
        for (int i = 0; i < fetch_waits; i++) push(1'b0, v_fetch(1'b0), "sw_fetch_wait");
        push(1'b1, v_fetch(1'b1), "sw_fetch");
        push(1'b1, v_decode(), "sw_decode");
        push(1'b1, v_memaddr(), "sw_addr");
        push(1'b1, v_memwr(), "sw_wr");
        drain();
        retired_exp++;
    endtask

    task automatic do_beq(input logic z);
        OPCODE = 6'h04;
        FUNCT  = 6'h00;
        ZERO   = z;
        push(1'b1, v_fetch(1'b1), "beq_fetch");
        push(1'b1, v_decode(), "beq_decode");
        push(1'b1, v_branch(), "beq_branch");
        drain();
        retired_exp++;
    endtask

    task automatic do_j();
        OPCODE = 6'h03;
        FUNCT  = 6'h00;
        push(1'b1, v_fetch(1'b1), "j_fetch");
        push(1'b0, v_decode(), "j_decode");
        push(1'b0, v_jump(), "j_jump");
        drain();
        retired_exp++;
    endtask

    task automatic do_illegal(input logic [5:0] op, input logic [5:0] fn);
        OPCODE = op;
        FUNCT  = fn;
        push(1'b1, v_fetch(1'b1), "ill_fetch");
        push(1'b1, v_decode(), "ill_decode");
        push(1'b1, v_illegal(), "ill_state");
        drain();
    endtask

    initial begin
        RESET     = 1'b0;
        OPCODE    = 6'h23;
        FUNCT     = 6'h00;
        ZERO      = 1'b0;
        MEM_READY = 1'b1;

        // Reset held for three cycles: every output zero
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("reset_outputs", dut_vec, 23'd0);
`ifdef CTRL_PERF_CNT_EN
            check32("reset_cnt", RETIRED_CNT, 32'd0);
`endif
        end
        @(posedge CLK);
        #1;
        RESET = 1'b1;

        do_alu(6'h22, 4'd6, 1'b1);
        do_alu(6'h20, 4'd2, 1'b0);
        do_alu(6'h24, 4'd0, 1'b1);
        do_sw(1);
`ifdef CTRL_PERF_CNT_EN
        check32("cnt_after_4", RETIRED_CNT, 32'd4);
`endif
        do_alu(6'h25, 4'd1, 1'b1);
        do_alu(6'h2A, 4'd7, 1'b0);
        do_alu(6'h00, 4'd2, 1'b1);
        do_lw(2);
        do_beq(1'b1);
        do_beq(1'b0);
        do_j();
        do_illegal(6'h3F, 6'h20);
        do_illegal(6'h02, 6'h3F);
`ifdef CTRL_PERF_CNT_EN
        check32("cnt_mid", RETIRED_CNT, 32'(retired_exp));
`endif

        // Store stalls in MEM_WR, then reset lands mid-instruction
        OPCODE = 6'h2B;
        push(1'b1, v_fetch(1'b1), "swr_fetch");
        push(1'b1, v_decode(), "swr_decode");
        push(1'b1, v_memaddr(), "swr_addr");
        push(1'b0, v_memwr(), "swr_wait");
        drain();
        check("swr_hold", dut_vec, v_memwr());
        RESET = 1'b0;
        #1;
        check("swr_reset_now", dut_vec, 23'd0);
`ifdef CTRL_PERF_CNT_EN
        check32("swr_reset_cnt", RETIRED_CNT, 32'd0);
`endif
        retired_exp = 0;
        @(negedge CLK);
        check("swr_reset_hold", dut_vec, 23'd0);
        @(posedge CLK);
        #1;
        RESET = 1'b1;

        do_j();
`ifdef CTRL_PERF_CNT_EN
        check32("cnt_after_reset", RETIRED_CNT, 32'(retired_exp));
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
